matvec_mac_engine: RTL

//   Consumes the row FIFOs filled by the memory fetch stage plus one vector FIFO.

---
 rtl/matvec_mac_engine_if.sv | 31 +++
 rtl/matvec_mac_engine.sv | 98 +++++++++
 2 files changed

// File: rtl/matvec_mac_engine_if.sv
// FIFO-side bus of the matrix-vector MAC engine: NUM_ROWS row FIFOs plus one vector FIFO.
// The engine is the master (issues pops); the FIFO bank is the slave.
interface matvec_mac_engine_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_ROWS   = 8
);
    logic [NUM_ROWS-1:0]                 row_rden;
    logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] row_rdata;
    logic [NUM_ROWS-1:0]                 row_empty;
    logic                                vec_rden;
    logic [DATA_WIDTH-1:0]               vec_rdata;
    logic                                vec_empty;

    modport master (
        output row_rden,
        output vec_rden,
        input  row_rdata,
        input  row_empty,
        input  vec_rdata,
        input  vec_empty
    );

    modport slave (
        input  row_rden,
        input  vec_rden,
        output row_rdata,
        output row_empty,
        output vec_rdata,
        output vec_empty
    );
endinterface

// File: rtl/matvec_mac_engine.sv
// Matrix-vector engine: pops one element from every row FIFO and the vector FIFO in lockstep
// and accumulates y[i] += A[i][k] * x[k] over VEC_LEN pops, then pulses done.
module matvec_mac_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned VEC_LEN    = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    matvec_mac_engine_if.master                 fifo,
    output logic [NUM_ROWS-1:0][ACC_WIDTH-1:0]  result
);

    localparam int unsigned CntW  = $clog2(VEC_LEN + 1);
    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned SumW  = (ACC_WIDTH > ProdW) ? ACC_WIDTH : ProdW;
    localparam logic [CntW-1:0] CntMax  = CntW'(VEC_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(VEC_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                               state_q;
    logic [CntW-1:0]                      cnt_q;
    logic                                 pop_d1_q;
    logic                                 busy_q;
    logic                                 done_q;
    logic [NUM_ROWS-1:0][ACC_WIDTH-1:0]   result_q;
    logic [NUM_ROWS-1:0][ACC_WIDTH-1:0]   mac_next;
    logic                                 pop;

    // A single empty anywhere stalls every lane so all FIFOs stay aligned.
    assign pop = (state_q == StRun) && !(|fifo.row_empty) && !fifo.vec_empty && (cnt_q < CntMax);

    assign fifo.row_rden = {NUM_ROWS{pop}};
    assign fifo.vec_rden = pop;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_mac
        logic [ProdW-1:0] prod;
        logic [SumW-1:0]  sum;
        assign prod        = ProdW'(fifo.row_rdata[i]) * ProdW'(fifo.vec_rdata);
        assign sum         = SumW'(result_q[i]) + SumW'(prod);
        assign mac_next[i] = sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pop_d1_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            pop_d1_q <= pop;
            // FIFO data arrives one cycle after the pop, so the MAC trails pop by a cycle.
            if (pop_d1_q) begin
                result_q <= mac_next;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StRun;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        result_q <= '0;
                    end
                end
                StRun: begin
                    if (pop) begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
